// File: rtl/ysyx_23060077_axi_sram.sv
// AXI4 responder backed by an on-chip word array; independent read and write
// FSMs over one shared memory, FIXED/INCR bursts with byte strobes.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH  32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH  32
`endif
`ifndef AXI_STRB_WIDTH
`define AXI_STRB_WIDTH  4
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH    4
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH   8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH  3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH  2
`endif

module ysyx_23060077_axi_sram #(
    parameter int unsigned                  DEPTH_WORDS = 1024,
    parameter logic [`AXI_ADDR_WIDTH-1:0]   BASE_ADDR   = 32'h0f00_0000
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            axi_sram_aw_valid_i,
    output logic                            axi_sram_aw_ready_o,
    input  logic [`AXI_ADDR_WIDTH-1:0]      axi_sram_aw_addr_i,
    input  logic [`AXI_ID_WIDTH-1:0]        axi_sram_aw_id_i,
    input  logic [`AXI_LEN_WIDTH-1:0]       axi_sram_aw_len_i,
    input  logic [`AXI_SIZE_WIDTH-1:0]      axi_sram_aw_size_i,
    input  logic [`AXI_BURST_WIDTH-1:0]     axi_sram_aw_burst_i,
    input  logic                            axi_sram_w_valid_i,
    output logic                            axi_sram_w_ready_o,
    input  logic [`AXI_DATA_WIDTH-1:0]      axi_sram_w_data_i,
    input  logic [`AXI_STRB_WIDTH-1:0]      axi_sram_w_strb_i,
    input  logic                            axi_sram_w_last_i,
    input  logic                            axi_sram_b_ready_i,
    output logic                            axi_sram_b_valid_o,
    output logic [`AXI_RESP_WIDTH-1:0]      axi_sram_b_resp_o,
    output logic [`AXI_ID_WIDTH-1:0]        axi_sram_b_id_o,
    input  logic                            axi_sram_ar_valid_i,
    output logic                            axi_sram_ar_ready_o,
    input  logic [`AXI_ADDR_WIDTH-1:0]      axi_sram_ar_addr_i,
    input  logic [`AXI_ID_WIDTH-1:0]        axi_sram_ar_id_i,
    input  logic [`AXI_LEN_WIDTH-1:0]       axi_sram_ar_len_i,
    input  logic [`AXI_SIZE_WIDTH-1:0]      axi_sram_ar_size_i,
    input  logic [`AXI_BURST_WIDTH-1:0]     axi_sram_ar_burst_i,
    input  logic                            axi_sram_r_ready_i,
    output logic                            axi_sram_r_valid_o,
    output logic [`AXI_DATA_WIDTH-1:0]      axi_sram_r_data_o,
    output logic [`AXI_RESP_WIDTH-1:0]      axi_sram_r_resp_o,
    output logic                            axi_sram_r_last_o,
    output logic [`AXI_ID_WIDTH-1:0]        axi_sram_r_id_o
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [`AXI_ADDR_WIDTH-1:0] SPAN = `AXI_ADDR_WIDTH'(DEPTH_WORDS * 4);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0, R_DATA = 1'b1;

    logic [`AXI_DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // Unsigned offset compare also rejects addresses below the base (they wrap high).
    function automatic logic in_range(input logic [`AXI_ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [`AXI_ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [1:0] start_err(input logic [`AXI_ADDR_WIDTH-1:0] a,
                                             input logic [2:0] size, input logic [1:0] burst);
        if (!in_range(a))                   return DECERR;
        if (size > 3'd2 || burst > 2'b01)   return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [`AXI_ADDR_WIDTH-1:0] next_addr(input logic [`AXI_ADDR_WIDTH-1:0] a,
                                                             input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b01) ? a + (`AXI_ADDR_WIDTH'(1) << size) : a;
    endfunction

    // ---------------- write channel ----------------
    logic [1:0]                  w_state_q, w_state_d;
    logic [`AXI_ADDR_WIDTH-1:0]  w_addr_q;
    logic [`AXI_ID_WIDTH-1:0]    w_id_q;
    logic [7:0]                  w_len_q, w_cnt_q;
    logic [2:0]                  w_size_q;
    logic [1:0]                  w_burst_q, w_resp_q, w_beat_resp;
    logic                        aw_hs, w_hs, w_is_last, w_we;

    assign aw_hs     = axi_sram_aw_valid_i && (w_state_q == W_IDLE);
    assign w_hs      = axi_sram_w_valid_i && (w_state_q == W_DATA);
    assign w_is_last = (w_cnt_q == w_len_q);
    assign w_we      = w_hs && !areset && (w_beat_resp == OKAY);

    // Running response after this beat; a mis-placed WLAST cannot downgrade DECERR.
    always_comb begin
        w_beat_resp = w_resp_q;
        if (!in_range(w_addr_q))
            w_beat_resp = DECERR;
        else if ((axi_sram_w_last_i != w_is_last) && (w_resp_q != DECERR))
            w_beat_resp = SLVERR;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (axi_sram_aw_valid_i) w_state_d = W_DATA;
            W_DATA:  if (axi_sram_w_valid_i && w_is_last) w_state_d = W_RESP;
            W_RESP:  if (axi_sram_b_ready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_resp_q  <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                w_addr_q  <= axi_sram_aw_addr_i;
                w_id_q    <= axi_sram_aw_id_i;
                w_len_q   <= axi_sram_aw_len_i;
                w_size_q  <= axi_sram_aw_size_i;
                w_burst_q <= axi_sram_aw_burst_i;
                w_resp_q  <= start_err(axi_sram_aw_addr_i, axi_sram_aw_size_i, axi_sram_aw_burst_i);
                w_cnt_q   <= '0;
            end
            if (w_hs) begin
                w_resp_q <= w_beat_resp;
                w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
                w_cnt_q  <= w_cnt_q + 8'd1;
            end
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < `AXI_STRB_WIDTH; b++)
                if (axi_sram_w_strb_i[b])
                    mem_q[word_idx(w_addr_q)][8*b +: 8] <= axi_sram_w_data_i[8*b +: 8];
        end
    end

    // ---------------- read channel ----------------
    logic                        r_state_q, r_state_d;
    logic [`AXI_ADDR_WIDTH-1:0]  r_addr_q, r_nxt;
    logic [`AXI_ID_WIDTH-1:0]    r_id_q;
    logic [7:0]                  r_len_q, r_cnt_q;
    logic [2:0]                  r_size_q;
    logic [1:0]                  r_burst_q, r_err_q, r_resp_q, ar_err, r_nxt_resp;
    logic [`AXI_DATA_WIDTH-1:0]  r_data_q;
    logic                        r_is_last;

    assign r_is_last  = (r_cnt_q == r_len_q);
    assign ar_err     = start_err(axi_sram_ar_addr_i, axi_sram_ar_size_i, axi_sram_ar_burst_i);
    assign r_nxt      = next_addr(r_addr_q, r_size_q, r_burst_q);
    assign r_nxt_resp = in_range(r_nxt) ? r_err_q : DECERR;

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (axi_sram_ar_valid_i) r_state_d = R_DATA;
            default: if (axi_sram_r_ready_i && r_is_last) r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_err_q   <= OKAY;
            r_resp_q  <= OKAY;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (r_state_q == R_IDLE && axi_sram_ar_valid_i) begin
                r_addr_q  <= axi_sram_ar_addr_i;
                r_id_q    <= axi_sram_ar_id_i;
                r_len_q   <= axi_sram_ar_len_i;
                r_size_q  <= axi_sram_ar_size_i;
                r_burst_q <= axi_sram_ar_burst_i;
                r_err_q   <= ar_err;
                r_cnt_q   <= '0;
                r_resp_q  <= ar_err;
                r_data_q  <= (ar_err == OKAY) ? mem_q[word_idx(axi_sram_ar_addr_i)] : '0;
            end else if (r_state_q == R_DATA && axi_sram_r_ready_i && !r_is_last) begin
                r_addr_q <= r_nxt;
                r_cnt_q  <= r_cnt_q + 8'd1;
                r_resp_q <= r_nxt_resp;
                r_data_q <= (r_nxt_resp == OKAY) ? mem_q[word_idx(r_nxt)] : '0;
            end
        end
    end

    // Outputs are forced quiet for the whole reset cycle, not just after the edge.
    assign axi_sram_aw_ready_o = !areset && (w_state_q == W_IDLE);
    assign axi_sram_w_ready_o  = !areset && (w_state_q == W_DATA);
    assign axi_sram_b_valid_o  = !areset && (w_state_q == W_RESP);
    assign axi_sram_b_resp_o   = areset ? '0 : w_resp_q;
    assign axi_sram_b_id_o     = areset ? '0 : w_id_q;
    assign axi_sram_ar_ready_o = !areset && (r_state_q == R_IDLE);
    assign axi_sram_r_valid_o  = !areset && (r_state_q == R_DATA);
    assign axi_sram_r_last_o   = !areset && (r_state_q == R_DATA) && r_is_last;
    assign axi_sram_r_data_o   = areset ? '0 : r_data_q;
    assign axi_sram_r_resp_o   = areset ? '0 : r_resp_q;
    assign axi_sram_r_id_o     = areset ? '0 : r_id_q;

endmodule

// File: tb/tb_ysyx_23060077_axi_sram.sv
// Randomised scoreboard bench for ysyx_23060077_axi_sram: a word-array model
// predicts every B and R beat; a negedge monitor pops and compares.
module tb_ysyx_23060077_axi_sram;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0f00_0000;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    logic aclk = 1'b0, areset = 1'b1;
    logic aw_valid = 0, aw_ready; logic [31:0] aw_addr = 0; logic [3:0] aw_id = 0;
    logic [7:0] aw_len = 0; logic [2:0] aw_size = 0; logic [1:0] aw_burst = 0;
    logic w_valid = 0, w_ready; logic [31:0] w_data = 0; logic [3:0] w_strb = 0; logic w_last = 0;
    logic b_ready = 0, b_valid; logic [1:0] b_resp; logic [3:0] b_id;
    logic ar_valid = 0, ar_ready; logic [31:0] ar_addr = 0; logic [3:0] ar_id = 0;
    logic [7:0] ar_len = 0; logic [2:0] ar_size = 0; logic [1:0] ar_burst = 0;
    logic r_ready = 0, r_valid; logic [31:0] r_data; logic [1:0] r_resp; logic r_last; logic [3:0] r_id;

    always #5 aclk = ~aclk;

    ysyx_23060077_axi_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .aclk(aclk), .areset(areset),
        .axi_sram_aw_valid_i(aw_valid), .axi_sram_aw_ready_o(aw_ready), .axi_sram_aw_addr_i(aw_addr),
        .axi_sram_aw_id_i(aw_id), .axi_sram_aw_len_i(aw_len), .axi_sram_aw_size_i(aw_size),
        .axi_sram_aw_burst_i(aw_burst),
        .axi_sram_w_valid_i(w_valid), .axi_sram_w_ready_o(w_ready), .axi_sram_w_data_i(w_data),
        .axi_sram_w_strb_i(w_strb), .axi_sram_w_last_i(w_last),
        .axi_sram_b_ready_i(b_ready), .axi_sram_b_valid_o(b_valid), .axi_sram_b_resp_o(b_resp),
        .axi_sram_b_id_o(b_id),
        .axi_sram_ar_valid_i(ar_valid), .axi_sram_ar_ready_o(ar_ready), .axi_sram_ar_addr_i(ar_addr),
        .axi_sram_ar_id_i(ar_id), .axi_sram_ar_len_i(ar_len), .axi_sram_ar_size_i(ar_size),
        .axi_sram_ar_burst_i(ar_burst),
        .axi_sram_r_ready_i(r_ready), .axi_sram_r_valid_o(r_valid), .axi_sram_r_data_o(r_data),
        .axi_sram_r_resp_o(r_resp), .axi_sram_r_last_o(r_last), .axi_sram_r_id_o(r_id)
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    logic [31:0] rx_q[$];
    int errors = 0, checks = 0;
    bit abort = 0;
    int rmode = 0, bmode = 0;
    logic [31:0] last_rdata = 0; logic [1:0] last_rresp = 0, last_bresp = 0;
    logic [3:0] last_rid = 0, last_bid = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + SPAN);
    endfunction

    function automatic int midx(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return int'(w[9:0]);
    endfunction

    function automatic logic [1:0] serr(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        if (!in_rng(a)) return 2'b11;
        if (size > 3'd2 || burst > 2'b01) return 2'b10;
        return 2'b00;
    endfunction

    // lmode 0: WLAST on the final beat; 1: on beat 0 only; 2: never.
    function automatic bit wlast(input int lmode, input int i, input logic [7:0] len);
        if (lmode == 0) return i == int'(len);
        if (lmode == 1) return i == 0;
        return 1'b0;
    endfunction

    // ch 0=AW, 1=W, 2=AR; n = cycles spent waiting before the handshake edge.
    task automatic hs_wait(input int ch, output int n);
        n = 0;
        if (abort) return;
        forever begin
            @(negedge aclk);
            if ((ch == 0 && aw_ready) || (ch == 1 && w_ready) || (ch == 2 && ar_ready)) break;
            n++;
            if (n > 3000) begin
                checks++; errors++; abort = 1;
                $display("FAIL hs_timeout: channel %0d ready never seen, required within 3000 cycles", ch);
                break;
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int lmode, input bit gaps);
        logic [1:0] resp; logic [31:0] a; bit lst; int n, k;
        resp = serr(addr, size, burst);
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            lst = wlast(lmode, i, len);
            if (!in_rng(a)) resp = 2'b11;
            else if (lst != (i == int'(len)) && resp != 2'b11) resp = 2'b10;
            if (resp == 2'b00)
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) mdl[midx(a)][8*b +: 8] = wdat[i][8*b +: 8];
            if (burst == 2'b01) a = a + (32'd1 << size);
        end
        bq.push_back('{resp: resp, id: id});
        aw_valid = 1; aw_addr = addr; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst;
        hs_wait(0, n);
        aw_valid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            w_valid = 1; w_data = wdat[i]; w_strb = wstb[i]; w_last = wlast(lmode, i, len);
            hs_wait(1, n);
            if (i == 0) chk(n == 0, "w_ready_latency", 64'(n), 0);
            w_valid = 0; w_last = 0;
            k = gaps ? int'($urandom_range(0, 2)) : 0;
            if (k > 0 && i < int'(len)) begin repeat (k) @(posedge aclk); #1; end
        end
        @(negedge aclk);
        chk(b_valid == 1'b1, "b_valid_latency", 64'(b_valid), 1);
        @(posedge aclk); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit lat_chk);
        logic [1:0] se, rs; logic [31:0] a; int n;
        se = serr(addr, size, burst);
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            rs = in_rng(a) ? se : 2'b11;
            rq.push_back('{data: (rs == 2'b00) ? mdl[midx(a)] : 32'h0, resp: rs, last: (i == int'(len)), id: id});
            if (burst == 2'b01) a = a + (32'd1 << size);
        end
        ar_valid = 1; ar_addr = addr; ar_id = id; ar_len = len; ar_size = size; ar_burst = burst;
        hs_wait(2, n);
        ar_valid = 0;
        if (lat_chk) begin
            @(negedge aclk);
            chk(r_valid == 1'b1, "r_valid_latency", 64'(r_valid), 1);
            @(posedge aclk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 5000) begin @(posedge aclk); n++; end
        chk(rq.size() == 0 && bq.size() == 0, "drain_pending", 64'(rq.size() + bq.size()), 0);
        @(posedge aclk); #1;
    endtask

    initial forever begin
        @(posedge aclk); #1;
        case (rmode) 0: r_ready = 1; 1: r_ready = ~r_ready; default: r_ready = 1'($urandom_range(0, 1)); endcase
        b_ready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: handshake happens at the posedge following a negedge that sees valid && ready.
    initial begin
        bit r_stall = 0, b_stall = 0;
        logic [38:0] pr = 0, cur_r; logic [5:0] pb = 0, cur_b;
        rexp_t re; bexp_t be;
        forever begin
            @(negedge aclk);
            if (areset) begin r_stall = 0; b_stall = 0; continue; end
            cur_r = {r_data, r_resp, r_last, r_id};
            cur_b = {b_resp, b_id};
            if (r_stall) chk(r_valid && cur_r == pr, "r_payload_stable", 64'(cur_r), 64'(pr));
            if (b_stall) chk(b_valid && cur_b == pb, "b_payload_stable", 64'(cur_b), 64'(pb));
            if (r_valid && r_ready) begin
                if (rq.size() == 0) chk(1'b0, "r_unexpected_beat", 64'(cur_r), 0);
                else begin
                    re = rq.pop_front();
                    chk(cur_r == {re.data, re.resp, re.last, re.id}, "r_beat{data,resp,last,id}",
                        64'(cur_r), 64'({re.data, re.resp, re.last, re.id}));
                end
                last_rdata = r_data; last_rresp = r_resp; last_rid = r_id;
                rx_q.push_back(r_data);
            end
            if (b_valid && b_ready) begin
                if (bq.size() == 0) chk(1'b0, "b_unexpected", 64'(cur_b), 0);
                else begin
                    be = bq.pop_front();
                    chk(cur_b == {be.resp, be.id}, "b{resp,id}", 64'(cur_b), 64'({be.resp, be.id}));
                end
                last_bresp = b_resp; last_bid = b_id;
            end
            r_stall = r_valid && !r_ready; pr = cur_r;
            b_stall = b_valid && !b_ready; pb = cur_b;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a; logic [2:0] sz; logic [1:0] bu; logic [7:0] ln; int lm;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, r_data, r_resp, b_resp, r_id, b_id} == '0,
            "reset_outputs", 64'({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, r_data, r_resp, b_resp, r_id, b_id}), 0);
        @(posedge aclk); #1; areset = 0;
        @(negedge aclk);
        chk(aw_ready && ar_ready, "ready_after_reset", 64'({aw_ready, ar_ready}), 64'(2'b11));
        @(posedge aclk); #1;

        // Fill the whole array so every later read has a defined model value.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            axi_write(BASE + 32'(k * 1024), 4'(k), 8'd255, 3'd2, 2'b01, 0, 0);
        end
        drain();

        // Single write then read.
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        axi_write(BASE + 32'h10, 4'h1, 8'd0, 3'd2, 2'b01, 0, 0);
        axi_read(BASE + 32'h10, 4'h2, 8'd0, 3'd2, 2'b01, 1);
        drain();
        chk(last_rdata == 32'hDEADBEEF && last_bresp == 2'b00, "single_rw", 64'({last_bresp, last_rdata}), 64'h0DEADBEEF);

        // Strobed write.
        wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
        axi_write(BASE + 32'h10, 4'h1, 8'd0, 3'd2, 2'b01, 0, 0);
        axi_read(BASE + 32'h10, 4'h2, 8'd0, 3'd2, 2'b01, 1);
        drain();
        chk(last_rdata == 32'hDE22BE44, "strobe_merge", 64'(last_rdata), 64'h DE22BE44);

        // INCR burst with toggling r_ready.
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
        axi_write(BASE + 32'h100, 4'h3, 8'd3, 3'd2, 2'b01, 0, 1);
        rmode = 1; rx_q.delete();
        axi_read(BASE + 32'h100, 4'h4, 8'd3, 3'd2, 2'b01, 1);
        drain();
        chk(rx_q.size() == 4, "burst_beat_count", 64'(rx_q.size()), 4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) chk(rx_q[i] == 32'(i + 1), "burst_order", 64'(rx_q[i]), 64'(i + 1));
        rmode = 0;

        // Errors.
        axi_read(BASE - 32'd4, 4'h6, 8'd0, 3'd2, 2'b01, 1);
        drain();
        chk(last_rresp == 2'b11 && last_rdata == 0, "ar_below_base", 64'({last_rresp, last_rdata}), 64'h3_0000_0000);
        wdat[0] = 32'h0BAD0BAD; wstb[0] = 4'hF;
        axi_write(BASE + 32'h10, 4'h7, 8'd0, 3'd3, 2'b01, 0, 0);
        axi_read(BASE + 32'h10, 4'h7, 8'd0, 3'd2, 2'b01, 0);
        drain();
        chk(last_bresp == 2'b10 && last_rdata == 32'hDE22BE44, "size3_slverr_unchanged",
            64'({last_bresp, last_rdata}), 64'h2_DE22BE44);
        wdat[1] = 32'h5555AAAA; wstb[1] = 4'hF;
        axi_write(BASE + 32'h20, 4'h8, 8'd1, 3'd2, 2'b01, 1, 0);
        drain();
        chk(last_bresp == 2'b10, "early_wlast", 64'(last_bresp), 2);

        // Overlapping read and write bursts with distinct ids.
        for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        rmode = 2; bmode = 1;
        fork
            axi_write(BASE + 32'h200, 4'h5, 8'd7, 3'd2, 2'b01, 0, 1);
            axi_read(BASE + 32'h300, 4'h9, 8'd7, 3'd2, 2'b01, 0);
        join
        drain();
        chk(last_bid == 4'h5 && last_rid == 4'h9, "concurrent_ids", 64'({last_bid, last_rid}), 64'h59);
        rmode = 0; bmode = 0;

        // Reset in the middle of a read burst.
        axi_read(BASE + 32'h40, 4'h3, 8'd7, 3'd2, 2'b01, 0);
        @(posedge aclk); #1;
        areset = 1;
        @(negedge aclk);
        chk(!r_valid && !ar_ready, "rst_mid_burst", 64'({r_valid, ar_ready}), 0);
        @(posedge aclk); #1;
        rq.delete(); bq.delete();
        areset = 0;
        @(negedge aclk);
        chk(ar_ready && !r_valid, "post_rst_idle", 64'({ar_ready, r_valid}), 64'(2'b10));
        @(posedge aclk); #1;

        // Randomised mix, including range edges, bad sizes/bursts and WLAST errors.
        for (int t = 0; t < 60 && !abort; t++) begin
            rmode = int'($urandom_range(0, 2)); bmode = int'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = BASE - 32'(4 * $urandom_range(1, 4));
                1: a = BASE + SPAN - 32'(4 * $urandom_range(1, 3));
                default: a = BASE + 32'($urandom_range(0, DEPTH - 1) << 2);
            endcase
            sz = ($urandom_range(0, 7) == 0) ? 3'd3 : (($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 1)) : 3'd2);
            bu = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            ln = 8'($urandom_range(0, 7));
            lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
            if (t % 2 == 0) axi_write(a, 4'($urandom), ln, sz, bu, lm, 1);
            else            axi_read(a, 4'($urandom), ln, sz, bu, 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
